// File: rtl/i2s_tx_if.sv
// i2s_tx_if: sample handshake between the volume stage and the I2S transmitter
interface i2s_tx_if;
  logic [15:0] lft_in;
  logic [15:0] rht_in;
  logic        vld;
  logic        rdy;
  modport master (output lft_in, rht_in, vld, input rdy);
  modport slave  (input lft_in, rht_in, vld, output rdy);
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: CS4272 I2S transmitter with codec clock/reset generation and a one-deep sample buffer
module i2s_tx #(
  parameter int RST_FRAMES = 4,
  parameter int UNDRN_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  i2s_tx_if.slave            bus,
  output logic               MCLK,
  output logic               SCLK,
  output logic               LRCLK,
  output logic               RSTn,
  output logic               SDin,
  output logic [UNDRN_W-1:0] undrn_cnt
);
  localparam int FW = $clog2(RST_FRAMES + 1);
  typedef enum logic {RST_HOLD, RUN} state_t;
  state_t state, state_nxt;
  logic [9:0] clk_cnt;
  logic [FW-1:0] frm_cnt;
  logic [15:0] hold_l, hold_r, last_l, last_r, sh_l, sh_r;
  logic hold_full, load, bit_end, acc, lslot, rslot;
  logic [5:0] nb;
  assign MCLK    = clk_cnt[1];
  assign SCLK    = clk_cnt[3];
  assign LRCLK   = clk_cnt[9];
  assign load    = clk_cnt == 10'd1023;
  assign bit_end = clk_cnt[3:0] == 4'hf;
  assign nb      = clk_cnt[9:4] + 6'd1;
  assign lslot   = nb >= 6'd1 && nb <= 6'd24;
  assign rslot   = nb >= 6'd33 && nb <= 6'd56;
  assign acc     = bus.vld & bus.rdy;
  always_comb begin
    state_nxt = (state == RST_HOLD && load && frm_cnt == FW'(RST_FRAMES - 1)) ? RUN : state;
    RSTn      = state == RUN;
    bus.rdy   = state == RUN && !hold_full;
  end
  // SDin is set one clk before each slot starts so it toggles with SCLK falling;
  // shifting zeros in behind the 16-bit sample yields the 8-bit zero pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_HOLD;
      clk_cnt   <= '0;
      frm_cnt   <= '0;
      SDin      <= 1'b0;
      undrn_cnt <= '0;
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      last_l    <= '0;
      last_r    <= '0;
      sh_l      <= '0;
      sh_r      <= '0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt + 10'd1;
      if (state == RST_HOLD && load) frm_cnt <= frm_cnt + FW'(1);
      if (acc && !load) begin
        hold_l    <= bus.lft_in;
        hold_r    <= bus.rht_in;
        hold_full <= 1'b1;
      end
      if (bit_end) begin
        SDin <= (lslot & sh_l[15]) | (rslot & sh_r[15]);
        if (lslot) sh_l <= sh_l << 1;
        if (rslot) sh_r <= sh_r << 1;
      end
      if (load) begin
        if (state == RST_HOLD) begin
          {sh_l, sh_r, last_l, last_r} <= '0;
        end else if (hold_full) begin
          {sh_l, sh_r, last_l, last_r} <= {hold_l, hold_r, hold_l, hold_r};
          hold_full <= 1'b0;
        end else if (acc) begin
          {sh_l, sh_r, last_l, last_r} <= {bus.lft_in, bus.rht_in, bus.lft_in, bus.rht_in};
        end else begin
          {sh_l, sh_r} <= {last_l, last_r};
          undrn_cnt    <= undrn_cnt + {{(UNDRN_W-1){1'b0}}, ~&undrn_cnt};
        end
      end
    end
  end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Serializes 16-bit left/right audio samples onto the CS4272 SDin line in I2S format.
- Generates the codec clocks MCLK, SCLK and LRCLK, plus the codec reset RSTn, from the 50 MHz system clock.
- It is the transmit end of the codec serial link, sitting between the equalizer output (volume stage) and the CS4272 pins.
- Input uses a one-deep valid/ready holding buffer; a starved frame repeats the previous sample and counts an underrun.

Parameters:
- RST_FRAMES, 4: number of full LRCLK frames RSTn is held low after rst_n deasserts.
- UNDRN_W, 8: width of the saturating underrun counter.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- lft_in  in  16  signed left sample.
- rht_in  in  16  signed right sample.
- vld  in  1  lft_in/rht_in valid.
- rdy  out  1  holding buffer empty; a sample is accepted when vld & rdy are both high on a clk edge.
- MCLK  out  1  codec master clock, clk/4.
- SCLK  out  1  serial bit clock, clk/16.
- LRCLK  out  1  frame clock, clk/1024 (48.828 kHz); low = left slot.
- RSTn  out  1  codec reset, active low.
- SDin  out  1  serial data to codec.
- undrn_cnt  out  UNDRN_W  saturating count of frames sent without fresh data.

Behaviour:
- Clock generation:
  - 10-bit free-running counter clk_cnt, reset to 0, increments every clk and wraps 1023 -> 0.
  - MCLK = clk_cnt[1], SCLK = clk_cnt[3], LRCLK = clk_cnt[9].
  - All three are flop-driven, reset 0, and never stop (the codec needs MCLK while in reset).
- Frame format:
  - Bit slot b = clk_cnt[9:4], range 0..63.
  - Slots b=1..24 carry left shift bits 23..0; b=33..56 carry right shift bits 23..0. All other slots drive 0.
  - Each channel's 24-bit word is {sample, 8'h00}, MSB first, one SCLK after the LRCLK edge (I2S delay).
  - SDin is registered and updates on the clk where clk_cnt[3:0]==15, so it changes coincident with the SCLK falling edge and is stable at SCLK rise.
- States:
  - RST_HOLD (reset state): RSTn=0, SDin=0, rdy=0. A frame counter increments on each clk_cnt==1023. On the RST_FRAMES-th such cycle, go to RUN.
  - RUN: RSTn=1, rdy = ~hold_full. Stays in RUN until rst_n asserts.
- Holding buffer:
  - On vld & rdy, capture lft_in/rht_in into the hold registers and set hold_full. rdy drops the next cycle.
  - vld while rdy=0 is ignored; the source must hold its data.
- Load point (clk_cnt==1023):
  - Shift registers load for the next frame.
  - If hold_full: load the hold data and clear hold_full.
  - Else if vld & rdy in the same cycle: bypass, load lft_in/rht_in directly; hold_full stays 0.
  - Else: reload the previous sample and increment undrn_cnt, saturating at all-ones.
  - On the RST_HOLD -> RUN transition cycle, load zeros and do not count an underrun.
- Latency: a sample accepted during frame N appears on SDin starting at slot 1 of frame N+1 (about 1040 clk after the load point at most).
- Reset mid-operation: rst_n low immediately forces clk_cnt, all clocks, SDin, rdy, RSTn, undrn_cnt, shift/hold registers and hold_full to 0, and the state to RST_HOLD. The codec goes back into reset.
- Arithmetic: samples pass through bit-exact; no rounding or sign extension (the low 8 bits are zero-padded).

Test Plan:
1. Reset release, RST_FRAMES=4 -> RSTn rises exactly 4096 clk after rst_n deasserts; MCLK period 80 ns, SCLK 320 ns, LRCLK 20.48 us; SDin=0 and rdy=0 throughout RST_HOLD.
2. Single sample lft=16'h8001, rht=16'h7FFE accepted in frame 0 -> frame 1 serial capture on SCLK rise gives left 24'h800100, right 24'h7FFE00; padding slots read 0.
3. Back-to-back: source offers a new sample every frame with vld held high -> rdy deasserts one cycle after each accept and reasserts the cycle after each load point; 100 frames match the sent data; undrn_cnt stays 0.
4. Starvation: send 16'h1234/16'h5678, then no vld for 3 frames -> the same word repeats 3 times; undrn_cnt=3. Then 300 starved frames -> undrn_cnt saturates at 255.
5. Bypass: vld rises exactly at clk_cnt==1023 with the buffer empty -> data appears in the next frame, hold_full stays 0, and no underrun is counted for that frame.
6. Mid-frame reset: assert rst_n during a right-slot bit -> all outputs go to 0 asynchronously; after release the full RST_HOLD sequence repeats and the first RUN frame transmits zeros.
